// File: rtl/m_axis_pkt_fifo.sv
// AXI4-Stream master output FIFO with fill level, almost-full, overflow pulse
// and optional store-and-forward gating on TLAST.
module m_axis_pkt_fifo #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int AF_THRESH   = 12,
  parameter int PACKET_MODE = 0
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESETN,
  input  logic                            wr_en,
  input  logic [TDATA_WIDTH-1:0]          data_in,
  input  logic [TDATA_WIDTH/8-1:0]        keep_in,
  input  logic [TUSER_WIDTH-1:0]          user_in,
  input  logic                            last_in,
  output logic                            full,
  output logic                            almost_full,
  output logic [$clog2(FIFO_DEPTH):0]     fill_level,
  output logic                            overflow,
  output logic [TDATA_WIDTH-1:0]          M_AXIS_TDATA,
  output logic [TDATA_WIDTH/8-1:0]        M_AXIS_TKEEP,
  output logic [TUSER_WIDTH-1:0]          M_AXIS_TUSER,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY
);

  localparam int KW = TDATA_WIDTH / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = TDATA_WIDTH + KW + TUSER_WIDTH + 1;

  typedef enum logic {GATE_CLOSED, GATE_OPEN} gate_t;

  logic [BW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_fill, r_pkt_cnt;
  logic [BW-1:0] r_out;
  logic          r_valid, r_ovf;
  gate_t         r_gate;

  logic [LW-1:0] w_mem_cnt, w_pkt_next;
  logic          w_full, w_wr, w_hs, w_last_out, w_close, w_load;

  assign w_full     = (r_fill == LW'(FIFO_DEPTH));
  assign w_wr       = wr_en && !w_full;
  assign w_hs       = r_valid && M_AXIS_TREADY;
  assign w_last_out = r_out[0];
  // Beats waiting in memory, i.e. excluding the one held in the output register.
  assign w_mem_cnt  = r_fill - LW'(r_valid);

  always_comb begin
    w_pkt_next = r_pkt_cnt;
    case ({w_wr && last_in, w_hs && w_last_out})
      2'b10:   w_pkt_next = r_pkt_cnt + 1'b1;
      2'b01:   w_pkt_next = r_pkt_cnt - 1'b1;
      default: w_pkt_next = r_pkt_cnt;
    endcase
  end

  // Closing edge also suppresses the reload so TVALID falls with the TLAST handshake.
  assign w_close = (PACKET_MODE != 0) && w_hs && w_last_out &&
                   (w_pkt_next == '0) && !w_full;
  assign w_load  = (r_gate == GATE_OPEN) && !w_close && (w_mem_cnt != '0) &&
                   (!r_valid || M_AXIS_TREADY);

  always_ff @(posedge M_AXIS_ACLK) begin
    if (w_wr) r_mem[r_wptr] <= {data_in, keep_in, user_in, last_in};
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_fill    <= '0;
      r_pkt_cnt <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_load) begin
        r_out   <= r_mem[r_rptr];
        r_rptr  <= r_rptr + 1'b1;
        r_valid <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
      case ({w_wr, w_hs})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
      r_ovf     <= wr_en && w_full;
      r_pkt_cnt <= w_pkt_next;
    end
  end

  // Full forces the gate open so an over-long packet cannot deadlock the FIFO.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      r_gate <= (PACKET_MODE != 0) ? GATE_CLOSED : GATE_OPEN;
    end else begin
      case (r_gate)
        GATE_CLOSED: if ((r_pkt_cnt != '0) || w_full) r_gate <= GATE_OPEN;
        GATE_OPEN:   if (w_close) r_gate <= GATE_CLOSED;
        default:     r_gate <= GATE_OPEN;
      endcase
    end
  end

  assign {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TUSER, M_AXIS_TLAST} = r_out;
  assign M_AXIS_TVALID = r_valid;
  assign fill_level    = r_fill;
  assign full          = w_full;
  assign almost_full   = (r_fill >= LW'(AF_THRESH));
  assign overflow      = r_ovf;

endmodule

// File: tb/tb_m_axis_pkt_fifo.sv
// Scoreboard bench: a cut-through instance (A) with a level/overflow model and a
// packet-mode instance (B) checking gate behaviour.
module tb_m_axis_pkt_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_wr = 0, a_last = 0, a_tready = 0;
  logic [31:0] a_data = '0;
  logic [3:0]  a_keep = '0;
  logic [0:0]  a_user = '0;
  logic        a_full, a_af, a_ovf, a_tlast, a_tvalid;
  logic [4:0]  a_fill;
  logic [31:0] a_tdata;
  logic [3:0]  a_tkeep;
  logic [0:0]  a_tuser;

  logic        b_wr = 0, b_last = 0, b_tready = 0;
  logic [31:0] b_data = '0;
  logic [3:0]  b_keep = '0;
  logic [0:0]  b_user = '0;
  logic        b_full, b_af, b_ovf, b_tlast, b_tvalid;
  logic [4:0]  b_fill;
  logic [31:0] b_tdata;
  logic [3:0]  b_tkeep;
  logic [0:0]  b_tuser;

  m_axis_pkt_fifo #(.TDATA_WIDTH(32), .TUSER_WIDTH(1), .FIFO_DEPTH(16),
                    .AF_THRESH(12), .PACKET_MODE(0)) u_a (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .wr_en(a_wr), .data_in(a_data),
    .keep_in(a_keep), .user_in(a_user), .last_in(a_last), .full(a_full),
    .almost_full(a_af), .fill_level(a_fill), .overflow(a_ovf),
    .M_AXIS_TDATA(a_tdata), .M_AXIS_TKEEP(a_tkeep), .M_AXIS_TUSER(a_tuser),
    .M_AXIS_TLAST(a_tlast), .M_AXIS_TVALID(a_tvalid), .M_AXIS_TREADY(a_tready));

  m_axis_pkt_fifo #(.TDATA_WIDTH(32), .TUSER_WIDTH(1), .FIFO_DEPTH(16),
                    .AF_THRESH(12), .PACKET_MODE(1)) u_b (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .wr_en(b_wr), .data_in(b_data),
    .keep_in(b_keep), .user_in(b_user), .last_in(b_last), .full(b_full),
    .almost_full(b_af), .fill_level(b_fill), .overflow(b_ovf),
    .M_AXIS_TDATA(b_tdata), .M_AXIS_TKEEP(b_tkeep), .M_AXIS_TUSER(b_tuser),
    .M_AXIS_TLAST(b_tlast), .M_AXIS_TVALID(b_tvalid), .M_AXIS_TREADY(b_tready));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [37:0] qa[$];
  logic [37:0] qb[$];

  // Monitor A: level/flag model, hold-stability, in-order scoreboard.
  int          m_lvl = 0;
  logic        m_ovf_exp = 0;
  logic        p_stall = 0;
  logic [37:0] p_pay = '0;
  logic        a_hs, a_wok;
  logic [37:0] a_pay, a_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_lvl = 0; m_ovf_exp = 0; p_stall = 0;
      qa.delete();
    end else begin
      a_pay = {a_tdata, a_tkeep, a_tuser, a_tlast};
      check("a_fill", a_fill, m_lvl);
      check("a_full", a_full, m_lvl == 16);
      check("a_almost_full", a_af, m_lvl >= 12);
      check("a_overflow", a_ovf, m_ovf_exp);
      if (p_stall) begin
        check("a_hold_valid", a_tvalid, 1);
        check("a_hold_payload", a_pay, p_pay);
      end
      a_hs = a_tvalid && a_tready;
      if (a_hs) begin
        check("a_beat_expected", qa.size() != 0, 1);
        if (qa.size() != 0) begin
          a_exp = qa.pop_front();
          check("a_beat", a_pay, a_exp);
        end
      end
      a_wok = a_wr && (m_lvl != 16);
      m_ovf_exp = a_wr && (m_lvl == 16);
      if (a_wok) qa.push_back({a_data, a_keep, a_user, a_last});
      m_lvl = m_lvl + int'(a_wok) - int'(a_hs);
      p_stall = a_tvalid && !a_tready;
      p_pay = a_pay;
    end
  end

  logic [37:0] b_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      qb.delete();
    end else if (b_tvalid && b_tready) begin
      check("b_beat_expected", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        b_exp = qb.pop_front();
        check("b_beat", {b_tdata, b_tkeep, b_tuser, b_tlast}, b_exp);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr_a(input logic [31:0] d, input logic l);
    a_wr = 1; a_data = d; a_keep = d[3:0]; a_user = d[0]; a_last = l;
    @(posedge clk); #1;
    a_wr = 0;
  endtask

  task automatic wr_b(input logic [31:0] d, input logic l);
    b_wr = 1; b_data = d; b_keep = d[3:0]; b_user = d[1]; b_last = l;
    qb.push_back({d, d[3:0], d[1], l});
    @(posedge clk); #1;
    b_wr = 0;
  endtask

  task automatic drain_a(input string tag);
    int k;
    a_tready = 1;
    for (k = 0; k < 200 && (qa.size() != 0 || a_fill != 0); k++) begin
      @(posedge clk); #1;
    end
    check(tag, qa.size(), 0);
    a_tready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, cyc, k;
    idle(3);
    rst_n = 1;
    idle(2);

    // Reset mid-stream
    a_tready = 0;
    for (int i = 0; i < 5; i++) wr_a(32'h500 + i, 0);
    idle(1);
    #2 rst_n = 0;
    #1;
    check("rst_fill", a_fill, 0);
    check("rst_valid", a_tvalid, 0);
    check("rst_payload", {a_tdata, a_tkeep, a_tuser, a_tlast}, 0);
    check("rst_flags", {a_full, a_af, a_ovf}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    idle(2);
    check("post_rst_fill", a_fill, 0);
    check("post_rst_valid", a_tvalid, 0);

    // Fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) wr_a(32'(i), i == 15);
    check("fill16_full", a_full, 1);
    wr_a(32'hAA, 0);
    check("ovf_pulse", a_ovf, 1);
    idle(1);
    check("ovf_clear", a_ovf, 0);
    drain_a("fill_drain");
    check("fill_drain_level", a_fill, 0);

    // Cut-through latency
    wr_a(32'h100, 0);
    @(negedge clk);
    check("lat_e0", a_tvalid, 0);
    @(negedge clk);
    check("lat_e1", a_tvalid, 1);
    @(posedge clk); #1;

    // Simultaneous write and read at level 8 and at full
    for (int i = 1; i < 8; i++) wr_a(32'h100 + i, 0);
    idle(2);
    a_tready = 1; a_wr = 1; a_data = 32'h200; a_keep = 4'h3; a_user = 0; a_last = 1;
    @(posedge clk); #1;
    a_wr = 0; a_tready = 0;
    check("sim8_level", a_fill, 8);
    for (int i = 0; i < 8; i++) wr_a(32'h210 + i, 0);
    a_tready = 1; a_wr = 1; a_data = 32'h300; a_keep = 4'h1; a_user = 1; a_last = 0;
    @(posedge clk); #1;
    a_wr = 0; a_tready = 0;
    check("sim16_level", a_fill, 15);
    check("sim16_ovf", a_ovf, 1);
    drain_a("sim_drain");

    // Random stall, 1000 beats
    sent = 0;
    for (cyc = 0; cyc < 8000 && sent < 1000; cyc++) begin
      a_wr = ($urandom_range(0, 3) != 0);
      a_data = $urandom; a_keep = a_data[7:4]; a_user = a_data[8];
      a_last = ($urandom_range(0, 7) == 0);
      a_tready = $urandom_range(0, 1);
      if (a_wr) sent++;
      @(posedge clk); #1;
    end
    a_wr = 0;
    check("stall_sent", sent, 1000);
    drain_a("stall_drain");

    // Packet mode: gate waits for TLAST
    b_tready = 1;
    for (int i = 0; i < 4; i++) wr_b(32'hB00 + i, 0);
    idle(4);
    check("pkt_closed", b_tvalid, 0);
    wr_b(32'hB04, 1);
    @(negedge clk);
    check("pkt_e0", b_tvalid, 0);
    @(negedge clk);
    check("pkt_e1", b_tvalid, 0);
    @(negedge clk);
    check("pkt_e2", b_tvalid, 1);
    @(posedge clk); #1;
    for (k = 0; k < 50 && qb.size() != 0; k++) begin @(posedge clk); #1; end
    check("pkt_drained", qb.size(), 0);

    // Packet mode: over-long packet forces release at full
    for (int i = 0; i < 15; i++) wr_b(32'hC00 + i, 0);
    idle(3);
    check("long_closed", b_tvalid, 0);
    wr_b(32'hC0F, 0);
    check("long_full", b_full, 1);
    for (k = 0; k < 10 && !b_tvalid; k++) begin @(posedge clk); #1; end
    check("long_release", b_tvalid, 1);
    for (k = 0; k < 60 && qb.size() != 0; k++) begin @(posedge clk); #1; end
    check("long_drained", qb.size(), 0);
    idle(2);
    check("long_level", b_fill, 0);
    wr_b(32'hD00, 0);
    @(negedge clk);
    @(negedge clk);
    check("gate_still_open", b_tvalid, 1);
    @(posedge clk); #1;
    wr_b(32'hD01, 1);
    idle(4);
    wr_b(32'hD02, 0);
    idle(5);
    check("gate_reclosed", b_tvalid, 0);
    check("gate_reclosed_level", b_fill, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
